// File: rtl/axi_lite_intr_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite interrupt controller slave.
package axi_lite_intr_pkg;

    localparam logic [4:0] GIE_OFS = 5'h00;
    localparam logic [4:0] IER_OFS = 5'h04;
    localparam logic [4:0] ISR_OFS = 5'h08;
    localparam logic [4:0] IAR_OFS = 5'h0C;
    localparam logic [4:0] IPR_OFS = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axi_lite_intr_slave_capture.sv
// Per-source interrupt capture: edge or level detect into a sticky ISR with set-over-clear priority.
module intr_capture #(
    parameter int                    NUM_INTR  = 1,
    parameter logic [NUM_INTR-1:0]   INTR_EDGE = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_INTR-1:0] intr_src,
    input  logic [NUM_INTR-1:0] clr,
    output logic [NUM_INTR-1:0] isr
);

    logic [NUM_INTR-1:0] intr_src_q;
    logic [NUM_INTR-1:0] set;

    assign set = (INTR_EDGE & intr_src & ~intr_src_q) | (~INTR_EDGE & intr_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_src_q <= '0;
            isr        <= '0;
        end else begin
            intr_src_q <= intr_src;
            // A new set in the clearing cycle must not be lost.
            isr        <= (isr & ~clr) | set;
        end
    end

endmodule

// File: rtl/axi_lite_intr_slave.sv
// AXI4-Lite interrupt controller register block (GIE/IER/ISR/IAR/IPR) with a registered irq output.
module axi_lite_intr_slave
    import axi_lite_intr_pkg::*;
#(
    parameter int                  NUM_INTR         = 1,
    parameter logic [NUM_INTR-1:0] INTR_EDGE        = '1,
    parameter logic                IRQ_ACTIVE_STATE = 1'b1,
    parameter int                  ADDR_WIDTH       = 5
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [NUM_INTR-1:0]   intr_src,
    output logic                  irq
);

    wr_state_e           wr_state, wr_next;
    rd_state_e           rd_state, rd_next;
    logic                wr_rdy, wr_rdy_d, bvalid_d, wr_en;
    logic                ar_rdy, ar_rdy_d, rvalid_d, rd_en;
    logic                gie;
    logic [NUM_INTR-1:0] ier, ier_wr, isr, clr;
    logic [31:0]         byte_mask, rd_word;
    logic [1:0]          wr_resp, rd_resp;
    logic [2:0]          wr_word, rd_word_idx;
    logic                unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr, s_axi_wdata};

    assign s_axi_awready = wr_rdy;
    assign s_axi_wready  = wr_rdy;
    assign s_axi_arready = ar_rdy;

    assign wr_word     = s_axi_awaddr[4:2];
    assign rd_word_idx = s_axi_araddr[4:2];
    assign byte_mask   = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                          {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    assign ier_wr      = (ier & ~byte_mask[NUM_INTR-1:0]) |
                         (s_axi_wdata[NUM_INTR-1:0] & byte_mask[NUM_INTR-1:0]);
    assign wr_resp     = (wr_word > IPR_OFS[4:2]) ? RESP_SLVERR : RESP_OKAY;
    assign clr         = (wr_en && wr_word == IAR_OFS[4:2]) ?
                         (s_axi_wdata[NUM_INTR-1:0] & byte_mask[NUM_INTR-1:0]) : '0;

    intr_capture #(
        .NUM_INTR  (NUM_INTR),
        .INTR_EDGE (INTR_EDGE)
    ) u_capture (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .intr_src (intr_src),
        .clr      (clr),
        .isr      (isr)
    );

    // Write channel: wait for both AW and W, one-cycle ready pulse, then hold B.
    always_comb begin
        wr_next  = wr_state;
        wr_rdy_d = 1'b0;
        bvalid_d = s_axi_bvalid;
        wr_en    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (wr_rdy) begin
                    wr_en    = 1'b1;
                    bvalid_d = 1'b1;
                    wr_next  = W_RESP;
                end else if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_rdy_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    wr_next  = W_IDLE;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state     <= W_IDLE;
            wr_rdy       <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            gie          <= 1'b0;
            ier          <= '0;
        end else begin
            wr_state     <= wr_next;
            wr_rdy       <= wr_rdy_d;
            s_axi_bvalid <= bvalid_d;
            if (wr_en) begin
                s_axi_bresp <= wr_resp;
                if (wr_word == GIE_OFS[4:2] && s_axi_wstrb[0]) gie <= s_axi_wdata[0];
                if (wr_word == IER_OFS[4:2]) ier <= ier_wr;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_word_idx)
            GIE_OFS[4:2]: rd_word[0]            = gie;
            IER_OFS[4:2]: rd_word[NUM_INTR-1:0] = ier;
            ISR_OFS[4:2]: rd_word[NUM_INTR-1:0] = isr;
            IAR_OFS[4:2]: rd_word               = '0;
            IPR_OFS[4:2]: rd_word[NUM_INTR-1:0] = isr & ier;
            default:      rd_resp               = RESP_SLVERR;
        endcase
    end

    // Read channel: one-cycle arready pulse, data latched on the handshake edge.
    always_comb begin
        rd_next  = rd_state;
        ar_rdy_d = 1'b0;
        rvalid_d = s_axi_rvalid;
        rd_en    = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (ar_rdy) begin
                    rd_en    = 1'b1;
                    rvalid_d = 1'b1;
                    rd_next  = R_DATA;
                end else if (s_axi_arvalid) begin
                    ar_rdy_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rd_next  = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state     <= R_IDLE;
            ar_rdy       <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            rd_state     <= rd_next;
            ar_rdy       <= ar_rdy_d;
            s_axi_rvalid <= rvalid_d;
            if (rd_en) begin
                s_axi_rdata <= rd_word;
                s_axi_rresp <= rd_resp;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq <= ~IRQ_ACTIVE_STATE;
        else          irq <= (gie && |(isr & ier)) ? IRQ_ACTIVE_STATE : ~IRQ_ACTIVE_STATE;
    end

endmodule

// File: tb/tb_axi_lite_intr_slave.sv
// Directed bench for axi_lite_intr_slave with a response scoreboard for B and R channels.
module tb_axi_lite_intr_slave;

    localparam int         NI   = 4;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NI-1:0] intr_src = '0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int         checks = 0;
    int         failures = 0;

    axi_lite_intr_slave #(
        .NUM_INTR         (NI),
        .INTR_EDGE        (4'b0111),
        .IRQ_ACTIVE_STATE (1'b1),
        .ADDR_WIDTH       (5)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .intr_src      (intr_src),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endfunction

    // Scoreboard monitor: compares every completed B or R handshake against the queued expectation.
    always @(negedge ACLK) begin
        if (ARESETN && bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", {31'b0, bvalid}, 32'd0);
            else chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
        end
        if (ARESETN && rvalid && rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected", {31'b0, rvalid}, 32'd0);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rdata", rdata, e.data);
                chk("rresp", {30'b0, rresp}, {30'b0, e.resp});
            end
        end
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input bit rise_src0);
        int n;
        bq.push_back(exp_resp);
        @(posedge ACLK); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!awready && n < 20);
        if (!awready) chk("aw_handshake", {31'b0, awready}, 32'd1);
        if (rise_src0) intr_src[0] = 1'b1;
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        rq.push_back('{data: exp_data, resp: exp_resp});
        @(posedge ACLK); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!arready && n < 20);
        if (!arready) chk("ar_handshake", {31'b0, arready}, 32'd1);
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge ACLK);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready",  {31'b0, wready},  32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        chk("rst_irq",     {31'b0, irq},     32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;

        for (int a = 0; a < 5; a++) axi_read(5'(a * 4), 32'd0, OKAY);
        axi_read(5'h14, 32'd0, SERR);

        // Enable source 0 and pulse it for one cycle.
        axi_write(5'h00, 32'h1, 4'hF, OKAY, 1'b0);
        axi_write(5'h04, 32'h1, 4'hF, OKAY, 1'b0);
        axi_read(5'h00, 32'h1, OKAY);
        axi_read(5'h04, 32'h1, OKAY);
        @(posedge ACLK); #1; intr_src[0] = 1'b1;
        @(posedge ACLK); #1; intr_src[0] = 1'b0;
        @(negedge ACLK); chk("irq_one_after_rise", {31'b0, irq}, 32'd0);
        @(negedge ACLK); chk("irq_two_after_rise", {31'b0, irq}, 32'd1);
        axi_read(5'h10, 32'h1, OKAY);
        axi_read(5'h08, 32'h1, OKAY);

        axi_write(5'h0C, 32'h1, 4'hF, OKAY, 1'b0);
        @(negedge ACLK); chk("irq_after_iar", {31'b0, irq}, 32'd0);
        axi_read(5'h10, 32'h0, OKAY);
        axi_read(5'h08, 32'h0, OKAY);

        // Held source with IER off, then enabled.
        axi_write(5'h04, 32'h0, 4'hF, OKAY, 1'b0);
        intr_src[0] = 1'b1;
        repeat (3) @(posedge ACLK);
        axi_read(5'h08, 32'h1, OKAY);
        axi_read(5'h10, 32'h0, OKAY);
        @(negedge ACLK); chk("irq_masked", {31'b0, irq}, 32'd0);
        axi_write(5'h04, 32'h1, 4'hF, OKAY, 1'b0);
        @(negedge ACLK); chk("irq_after_ier", {31'b0, irq}, 32'd1);
        axi_write(5'h04, 32'h0, 4'h0, OKAY, 1'b0);
        axi_read(5'h04, 32'h1, OKAY);
        intr_src[0] = 1'b0;
        axi_write(5'h0C, 32'h1, 4'hF, OKAY, 1'b0);
        @(negedge ACLK); chk("irq_after_clear2", {31'b0, irq}, 32'd0);
        axi_read(5'h08, 32'h0, OKAY);

        // AW ahead of W, then B stalled for four cycles on an unmapped offset.
        bq.push_back(SERR);
        bready = 1'b0;
        @(posedge ACLK); #1;
        awaddr = 5'h18; awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK); chk("aw_waits_for_w", {31'b0, awready}, 32'd0);
        end
        @(posedge ACLK); #1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!awready && n < 20);
        chk("aw_handshake_late", {31'b0, awready}, 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK); chk("bvalid_held", {31'b0, bvalid}, 32'd1);
        end
        @(posedge ACLK); #1; bready = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK); chk("bvalid_dropped", {31'b0, bvalid}, 32'd0);
        axi_read(5'h00, 32'h1, OKAY);
        axi_read(5'h04, 32'h1, OKAY);
        axi_read(5'h18, 32'h0, SERR);

        // IAR clear coinciding with a fresh edge: the set must win.
        axi_write(5'h0C, 32'h1, 4'hF, OKAY, 1'b1);
        axi_read(5'h08, 32'h1, OKAY);
        @(negedge ACLK); chk("irq_set_wins", {31'b0, irq}, 32'd1);

        // Level source re-sets immediately after clearing; edge source stays cleared.
        intr_src[3] = 1'b1;
        repeat (2) @(posedge ACLK);
        axi_read(5'h08, 32'h9, OKAY);
        axi_write(5'h0C, 32'hF, 4'hF, OKAY, 1'b0);
        axi_read(5'h08, 32'h8, OKAY);
        axi_read(5'h10, 32'h0, OKAY);
        @(negedge ACLK); chk("irq_level_masked", {31'b0, irq}, 32'd0);

        // Asynchronous reset while a read response is pending.
        rready = 1'b0;
        @(posedge ACLK); #1;
        araddr = 5'h08; arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!arready && n < 20);
        chk("ar_handshake_rst", {31'b0, arready}, 32'd1);
        @(posedge ACLK); #1; arvalid = 1'b0;
        @(negedge ACLK); chk("rvalid_before_rst", {31'b0, rvalid}, 32'd1);
        ARESETN = 1'b0; intr_src = '0;
        #1;
        chk("rvalid_async_rst", {31'b0, rvalid}, 32'd0);
        chk("rdata_async_rst", rdata, 32'd0);
        chk("irq_async_rst", {31'b0, irq}, 32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1; rready = 1'b1;
        axi_read(5'h00, 32'h0, OKAY);
        axi_read(5'h08, 32'h0, OKAY);

        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin @(negedge ACLK); n++; end
        chk("scoreboard_drained", 32'(bq.size() + rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_intr_slave.md
# axi_lite_intr_slave

AXI4-Lite responder that implements the IP's interrupt controller register block: global enable, per-source enable, raw status, pending and write-1-to-clear acknowledge registers, plus a single `irq` output. It sits on the IP's second AXI4-Lite slave port, alongside the data register slave. It is the target that the block-design bench drives through its second VIP master.

## Interface
Parameters:
- `NUM_INTR`, 1, number of interrupt sources (1..32)
- `INTR_EDGE`, all-ones `NUM_INTR` bits, per source: 1 = rising-edge capture, 0 = level
- `IRQ_ACTIVE_STATE`, 1, asserted level of `irq`
- `ADDR_WIDTH`, 5, AXI address width; data width fixed at 32

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `ACLK` in 1 clock
  - `ARESETN` in 1 asynchronous active-low reset
- Write address channel:
  - `s_axi_awaddr` in `ADDR_WIDTH` write address
  - `s_axi_awprot` in 3, ignored
  - `s_axi_awvalid` in 1; `s_axi_awready` out 1
- Write data channel:
  - `s_axi_wdata` in 32; `s_axi_wstrb` in 4
  - `s_axi_wvalid` in 1; `s_axi_wready` out 1
- Write response channel:
  - `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1
- Read address channel:
  - `s_axi_araddr` in `ADDR_WIDTH`; `s_axi_arprot` in 3, ignored
  - `s_axi_arvalid` in 1; `s_axi_arready` out 1
- Read data channel:
  - `s_axi_rdata` out 32; `s_axi_rresp` out 2
  - `s_axi_rvalid` out 1; `s_axi_rready` in 1
- Interrupt:
  - `intr_src` in `NUM_INTR` raw interrupt sources, synchronous to `ACLK`
  - `irq` out 1 combined interrupt

## Operation
- Register map (word offsets, `addr[4:2]`):
  - 0x00 GIE: bit0 R/W global enable.
  - 0x04 IER: `NUM_INTR` bits, R/W per-source enable.
  - 0x08 ISR: read-only raw captured status.
  - 0x0C IAR: write-1-to-clear ISR bits; reads 0.
  - 0x10 IPR: read-only, equals ISR & IER.
  - Unused bits read 0.
- Address decode:
  - Offsets 0x14–0x1C: writes are ignored, reads return 0, response SLVERR (2'b10).
  - All mapped accesses respond OKAY.
- `wstrb`: honoured per byte on GIE and IER. IAR clears only bits in strobed bytes.
- Status capture:
  - Edge sources: `intr_src_q` holds the previous sample. An ISR bit sets when `intr_src & ~intr_src_q`.
  - Level sources: the ISR bit sets whenever `intr_src` is high.
  - Capture is independent of IER and GIE.
- ISR bits stay set until cleared via IAR.
- If a set and an IAR clear of the same bit occur in the same cycle, set wins.
- `irq` is registered: it takes `IRQ_ACTIVE_STATE` when `GIE[0] && |(ISR & IER)`, otherwise the inverse.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE with `awvalid && wvalid` both high, pulse `awready` and `wready` together for one cycle, perform the register write, then go to W_RESP.
  - W_RESP holds `bvalid` until `bready`, then returns to W_IDLE.
  - AW alone or W alone is not accepted; the responder waits for both.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE with `arvalid`, pulse `arready` for one cycle, latch `rdata`/`rresp`, then go to R_DATA.
  - R_DATA holds `rvalid` with stable data until `rready`, then returns to R_IDLE.
- Reads and writes proceed concurrently.
- A read of IPR/ISR returns the value registered in the same cycle as the `arready` handshake.

## Timing
- Reset values: all readys 0, `bvalid`/`rvalid` 0, `bresp`/`rresp` 0, `rdata` 0. GIE, IER, ISR and `intr_src_q` are 0. `irq` = `~IRQ_ACTIVE_STATE`.
- Write latency:
  - `awready`/`wready` assert the cycle after both valids are seen.
  - `bvalid` asserts the cycle after the handshake.
  - The register update is visible in the same cycle `bvalid` rises.
- Read latency: `arready` asserts the cycle after `arvalid`; `rvalid` asserts the following cycle.
- Throughput: minimum 3 cycles per transaction per channel when `bready`/`rready` are tied high.
- Edge source to `irq`:
  - The source rising in cycle N sets ISR at edge N+1.
  - `irq` changes at edge N+2 if enabled.
- IAR write to `irq` deassert: `irq` drops 1 cycle after the ISR clear.
- Backpressure: a stalled `bready`/`rready` blocks new acceptance on that channel only.
- Asynchronous reset mid-transaction: all FSMs return to IDLE immediately. Outstanding responses are dropped and every output takes its reset value.

## Structure
- Shared package `axi_lite_intr_pkg`:
  - Register offset constants: `GIE_OFS`, `IER_OFS`, `ISR_OFS`, `IAR_OFS`, `IPR_OFS`.
  - Response constants: `RESP_OKAY`, `RESP_SLVERR`.
  - Enums `wr_state_e` and `rd_state_e`.
- One sub-module, `intr_capture`: per-source edge/level detect and ISR set/clear priority. The AXI FSMs stay in the top level.

## Test plan
- Reset, then read all five offsets → all return 0 with OKAY; `irq` = `~IRQ_ACTIVE_STATE`.
- Write 0x1 to 0x00, then 0x1 to 0x04, then pulse `intr_src[0]` for 1 cycle:
  - `irq` goes active 2 cycles after the rise.
  - Read of 0x10 returns 0x1.
- Write 0x1 to 0x0C → `irq` inactive; read 0x10 returns 0x0 and read 0x08 returns 0x0.
- Hold `intr_src[0]` high with IER = 0 → ISR reads 0x1, IPR reads 0x0, `irq` stays inactive. Then write IER = 1 → `irq` asserts.
- Assert AW 3 cycles before W, and hold `bready` low 4 cycles:
  - No `awready` until W arrives.
  - `bvalid` is held the full 4 cycles.
  - Write to 0x18 returns `bresp` 2'b10 and no register change.
- Issue an IAR write to bit0 in the same cycle as a new rising edge on `intr_src[0]` → ISR bit0 remains 1. Separately, drop `ARESETN` while `rvalid` is high → `rvalid` clears immediately.
